// File: rtl/bch_pkg.sv
// rtl/bch_pkg.sv - shared constants, state type and reference parity for the serial BCH encoder
`ifndef ECC_WORD_SIZE
`define ECC_WORD_SIZE 11
`endif
`ifndef ECC_RED_N_BITS
`define ECC_RED_N_BITS 4
`endif

package bch_pkg;

  localparam int BCH_DATA_W = `ECC_WORD_SIZE;
  localparam int BCH_PAR_W  = `ECC_RED_N_BITS;

  // x^4 + x + 1, MSB is the x^PAR_W coefficient
  localparam logic [BCH_PAR_W:0] BCH_GEN_POLY = 5'b10011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bch_state_t;

  // Long division of d(x)*x^par_w by poly; returns the remainder
  function automatic logic [63:0] bch_ref_parity(input logic [63:0] data,
                                                 input int data_w,
                                                 input int par_w,
                                                 input logic [64:0] poly);
    logic [127:0] rem;
    logic [63:0]  mask;
    rem  = 128'(data) << par_w;
    mask = (64'd1 << par_w) - 64'd1;
    for (int i = data_w + par_w - 1; i >= par_w; i--) begin
      if (rem[i]) rem = rem ^ (128'(poly) << (i - par_w));
    end
    return rem[63:0] & mask;
  endfunction

endpackage

// File: rtl/bch_lfsr_step.sv
// rtl/bch_lfsr_step.sv - combinational division step advancing the parity by BPC message bits
module bch_lfsr_step
  import bch_pkg::*;
#(
  parameter int               PAR_W    = BCH_PAR_W,
  parameter logic [PAR_W:0]   GEN_POLY = BCH_GEN_POLY,
  parameter int               BPC      = 1
) (
  input  logic [PAR_W-1:0] parity_in,
  input  logic [BPC-1:0]   bits,
  output logic [PAR_W-1:0] parity_out
);

  logic fb;

  // Clock BPC bits through the divider, highest-index bit first
  always_comb begin
    fb         = 1'b0;
    parity_out = parity_in;
    for (int i = BPC - 1; i >= 0; i--) begin
      fb         = bits[i] ^ parity_out[PAR_W-1];
      parity_out = {parity_out[PAR_W-2:0], 1'b0} ^ (fb ? GEN_POLY[PAR_W-1:0] : '0);
    end
  end

endmodule

// File: rtl/bch_enc_serial.sv
// rtl/bch_enc_serial.sv - serial systematic BCH encoder with valid/ready handshakes
module bch_enc_serial
  import bch_pkg::*;
#(
  parameter int             DATA_W   = `ECC_WORD_SIZE,
  parameter int             PAR_W    = `ECC_RED_N_BITS,
  parameter logic [PAR_W:0] GEN_POLY = BCH_GEN_POLY,
  parameter int             BPC      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_o,
  output logic [PAR_W-1:0]  ecc_o
);

  localparam int BPC_SAFE = (BPC < 1) ? 1 : BPC;
  localparam int NCYC     = DATA_W / BPC_SAFE;
  localparam int CNT_W    = $clog2(NCYC + 1);

  if (BPC < 1) begin : g_bad_bpc
    $error("bch_enc_serial: BPC must be at least 1");
  end else if ((DATA_W % BPC) != 0) begin : g_bad_div
    $error("bch_enc_serial: DATA_W must be a multiple of BPC");
  end

  bch_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  msg;
  logic [DATA_W-1:0]  msg_rot;
  logic [PAR_W-1:0]   lfsr;
  logic [PAR_W-1:0]   lfsr_next;

  // The message register rotates rather than shifts, so after NCYC steps
  // it holds the original word again and doubles as the systematic copy.
  assign msg_rot = (msg << BPC_SAFE) | (msg >> (DATA_W - BPC_SAFE));

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  bch_lfsr_step #(
    .PAR_W    (PAR_W),
    .GEN_POLY (GEN_POLY),
    .BPC      (BPC_SAFE)
  ) u_step (
    .parity_in  (lfsr),
    .bits       (msg[DATA_W-1 -: BPC_SAFE]),
    .parity_out (lfsr_next)
  );

  // Accept a word, feed it through the divider, then present it until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      msg    <= '0;
      lfsr   <= '0;
      data_o <= '0;
      ecc_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            msg   <= data_i;
            lfsr  <= '0;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt == CNT_W'(NCYC)) begin
            data_o <= msg;
            ecc_o  <= lfsr;
            state  <= ST_DONE;
          end else begin
            msg  <= msg_rot;
            lfsr <= lfsr_next;
            cnt  <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
